input_loader_ctrl: RTL and testbench
====================================

# input_loader_ctrl

Sequencing controller for the 24-bit byte-assembly input register. It accepts bytes from an 8-bit source with a valid/ready handshake and drives the register's `ld_reg`, `icc` and `inc` strobes. Once a full word (x = 16 bits, y = 8 bits) is assembled, it pulses `start` to the downstream compute unit. It then holds off further input until that unit reports `done`.

## Interface
Parameters:
- `NUM_BYTES`, default 3: bytes per assembled word; legal range 2..8.
- `TIMEOUT_CYCLES`, default 1024: `WAIT` watchdog limit. Used only when `TIMEOUT_EN` is defined.

Ports:
- `clk`: input, 1 bit. Clock; all state changes on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `en`: input, 1 bit. Enables byte acceptance. A word already being assembled is kept while low.
- `in_valid`: input, 1 bit. Source presents a byte on the shared bus.
- `in_ready`: output, 1 bit. Controller will accept the byte this cycle.
- `ld_reg`: output, 1 bit. Shift strobe to the assembly register.
- `icc`: output, 1 bit. Increment strobe to the register's byte counter.
- `inc`: output, 1 bit. Clear strobe to the register's byte counter.
- `start`: output, 1 bit. One-cycle pulse: the word is complete and stable.
- `done`: input, 1 bit. Downstream has consumed the word.
- `busy`: output, 1 bit. High in `START` and `WAIT`.
- `byte_cnt`: output, `$clog2(NUM_BYTES)` bits. Bytes accepted into the current word.
- `err`: output, 1 bit. Watchdog timeout pulse. Tied 0 without `TIMEOUT_EN`.

## Operation
- States: `LOAD`, `START`, `WAIT`. Reset enters `LOAD`.
- Reset values: `byte_cnt`=0; `start`, `inc`, `busy`, `err` = 0; `in_ready`=0 while `rst` is asserted.
- `LOAD`:
  - `in_ready` = `en`.
  - Accept = `in_valid & in_ready`.
  - On accept, `ld_reg`=1 and `icc`=1 combinationally in the same cycle, so the register captures the bus on that edge.
  - On a non-final accept, `byte_cnt` increments.
  - On the final accept (`byte_cnt == NUM_BYTES-1`), `byte_cnt` clears to 0 and the next state is `START`.
- `START` (exactly one cycle): `start`=1, `inc`=1, `busy`=1, `in_ready`=0. Next state is `WAIT`.
- `WAIT`:
  - `busy`=1, `in_ready`=0; `ld_reg` and `icc` stay 0.
  - `done`=1 returns to `LOAD`.
  - `done` is sampled only in `WAIT`. A `done` in `LOAD` or `START` is ignored.
- `en` falling mid-word: `byte_cnt` and the register contents are held. Assembly resumes when `en` returns.
- `in_valid` without `in_ready`: no strobes; the source must hold its byte.
- Reset mid-word or mid-`WAIT`: the partial word is abandoned, the state returns to `LOAD` with `byte_cnt`=0, and no `start` is issued.

## Timing
- Minimum word period: NUM_BYTES accept cycles + 1 `START` cycle + at least 1 `WAIT` cycle.
- With `done` returned the first `WAIT` cycle, throughput is 1 word per NUM_BYTES+2 cycles.
- `start` asserts the cycle after the final accept edge. The x/y outputs are valid in that cycle and stay stable until the next accept.
- `done` seen in `WAIT` at edge N gives `in_ready`=1 (if `en`) in cycle N+1.
- `ld_reg` and `icc` are Mealy outputs. `start`, `inc`, `busy` and `err` are Moore outputs decoded from the registered state.

## Configuration
- `INPUT_LOADER_TIMEOUT_EN` defined:
  - A cycle counter runs while in `WAIT` and clears on entry to `WAIT`.
  - Reaching `TIMEOUT_CYCLES` without `done` pulses `err` for 1 cycle and forces `LOAD`.
  - A `done` arriving in the same cycle as the timeout takes priority; `err` stays 0.
- Not defined: no counter, `err` tied 0, and `WAIT` is held indefinitely.

## Structure
- Shared package `input_loader_pkg`: state enum (`LOAD`, `START`, `WAIT`) and default constants `NUM_BYTES_DEF`=3 and `TIMEOUT_CYCLES_DEF`=1024.
- Optional sub-module `loader_watchdog` (counter plus compare, outputs `expired`), instantiated only under the macro.

## Test plan
- Bytes 0x11, 0x22, 0x33 on consecutive cycles with `en`=1 -> 3 `ld_reg`/`icc` pulses, then `start` and `inc` for 1 cycle; x=0x2211, y=0x33.
- `done` held 0 for 5 `WAIT` cycles, then 1 -> `in_ready`=0 throughout `WAIT`, then 1 the next cycle; a byte offered during `WAIT` is not loaded.
- `en` dropped after 2 bytes for 4 cycles, third byte 0x44 accepted after `en` returns -> `start` follows, y=0x44, `byte_cnt` held at 2 while low.
- `rst` pulse after 1 byte -> `byte_cnt`=0, no `start`; the next 3 bytes form a full word.
- `done` pulsed in `LOAD` and in `START` -> ignored; the controller stays in `WAIT` until a later `done`.
- With the macro and `TIMEOUT_CYCLES`=8, `done` never sent -> `err` pulses 8 cycles after `WAIT` entry and `in_ready` returns to 1; a second run with `done` in the expiry cycle -> `err`=0.

Source files
------------

// File: rtl/input_loader_pkg.sv
// input_loader_pkg: shared state encoding and default sizing for the input loader controller
package input_loader_pkg;
  localparam int NUM_BYTES_DEF      = 3;
  localparam int TIMEOUT_CYCLES_DEF = 1024;
  typedef enum logic [1:0] {LOAD, START, WAIT} state_t;
endpackage

// File: rtl/input_loader_ctrl_if.sv
// input_loader_ctrl_if: byte source handshake, register strobes and compute-unit handoff
interface input_loader_ctrl_if
  import input_loader_pkg::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEF
);
  logic                         en;
  logic                         in_valid;
  logic                         in_ready;
  logic                         ld_reg;
  logic                         icc;
  logic                         inc;
  logic                         start;
  logic                         done;
  logic                         busy;
  logic [$clog2(NUM_BYTES)-1:0] byte_cnt;
  logic                         err;
  modport master (
    input  en, in_valid, done,
    output in_ready, ld_reg, icc, inc, start, busy, byte_cnt, err
  );
  modport slave (
    output en, in_valid, done,
    input  in_ready, ld_reg, icc, inc, start, busy, byte_cnt, err
  );
endinterface

// File: rtl/input_loader_ctrl_watchdog.sv
// loader_watchdog: counts WAIT cycles and flags expiry after TIMEOUT_CYCLES without done
module loader_watchdog
  import input_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d     = run_i ? cnt_q + 1'b1 : '0;
  assign expired_o = run_i & (cnt_q == W'(TIMEOUT_CYCLES - 1));
  // Count while waiting; leaving WAIT clears, so each WAIT entry starts from zero.
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/input_loader_ctrl.sv
// input_loader_ctrl: sequences byte loads into the assembly register and hands words to compute; watchdog via INPUT_LOADER_TIMEOUT_EN
module input_loader_ctrl
  import input_loader_pkg::*;
#(
  parameter int NUM_BYTES      = NUM_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic                 clk,
  input logic                 rst,
  input_loader_ctrl_if.master bus
);
  localparam int CW = $clog2(NUM_BYTES);
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          start_q, busy_q, err_q;
  logic          accept, last, expired;
  assign last         = cnt_q == CW'(NUM_BYTES - 1);
  assign bus.in_ready = ~rst & bus.en & (state_q == LOAD);
  assign accept       = bus.in_valid & bus.in_ready;
  assign bus.ld_reg   = accept;
  assign bus.icc      = accept;
  assign bus.start    = start_q;
  assign bus.inc      = start_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.byte_cnt = cnt_q;
`ifdef INPUT_LOADER_TIMEOUT_EN
  loader_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .run_i     (state_q == WAIT),
    .expired_o (expired)
  );
`else
  assign expired = TIMEOUT_CYCLES < 0;
`endif
  // Word sequencing FSM; start/busy/err are registered alongside the state they decode.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        LOAD:
          if (accept) begin
            cnt_q <= last ? '0 : cnt_q + 1'b1;
            if (last) begin
              state_q <= START;
              start_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        START: state_q <= WAIT;
        WAIT:
          if (bus.done || expired) begin
            state_q <= LOAD;
            busy_q  <= 1'b0;
            err_q   <= ~bus.done;
          end
        default: state_q <= LOAD;
      endcase
    end
endmodule

// File: tb/tb_input_loader_ctrl.sv
// tb_input_loader_ctrl: directed checks of load/start/wait sequencing with a behavioural assembly register
module tb_input_loader_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'h00;
  logic [23:0] asm_q = 24'h0;
  int          n_run = 0;
  int          n_fail = 0;
  input_loader_ctrl_if #(.NUM_BYTES(3)) bus ();
  input_loader_ctrl #(.NUM_BYTES(3), .TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  // External 24-bit assembly register: byte 0 ends up in the low byte of x, last byte is y.
  always @(posedge clk)
    if (bus.ld_reg) asm_q <= {din, asm_q[23:8]};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic nxt();
    @(negedge clk);
  endtask
  initial begin
    bus.en = 1'b1; bus.in_valid = 1'b0; bus.done = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_byte_cnt", bus.byte_cnt, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_inc", bus.inc, 0);
    chk("rst_err", bus.err, 0);
    nxt(); rst = 1'b0;
    // word 11 22 33 on consecutive cycles
    bus.in_valid = 1'b1; din = 8'h11; #1;
    chk("w1_ready", bus.in_ready, 1);
    chk("w1_ld0", {bus.ld_reg, bus.icc}, 2'b11);
    chk("w1_cnt0", bus.byte_cnt, 0);
    nxt(); din = 8'h22; #1;
    chk("w1_ld1", {bus.ld_reg, bus.icc}, 2'b11);
    chk("w1_cnt1", bus.byte_cnt, 1);
    chk("w1_nostart1", bus.start, 0);
    nxt(); din = 8'h33; #1;
    chk("w1_ld2", {bus.ld_reg, bus.icc}, 2'b11);
    chk("w1_cnt2", bus.byte_cnt, 2);
    nxt(); din = 8'h55; #1;
    chk("w1_start", {bus.start, bus.inc, bus.busy}, 3'b111);
    chk("w1_start_ready", bus.in_ready, 0);
    chk("w1_start_ld", bus.ld_reg, 0);
    chk("w1_cnt_clr", bus.byte_cnt, 0);
    chk("w1_x", asm_q[15:0], 16'h2211);
    chk("w1_y", asm_q[23:16], 8'h33);
    // WAIT with done low for 5 cycles while a byte is offered
    for (int i = 0; i < 5; i++) begin
      nxt(); #1;
      chk("w1_wait_ready", bus.in_ready, 0);
      chk("w1_wait_strobes", {bus.ld_reg, bus.icc, bus.start, bus.inc}, 0);
      chk("w1_wait_busy", bus.busy, 1);
    end
    nxt(); bus.done = 1'b1; #1;
    chk("w1_done_ready", bus.in_ready, 0);
    nxt(); bus.done = 1'b0; bus.in_valid = 1'b0; #1;
    chk("w1_back_ready", bus.in_ready, 1);
    chk("w1_back_busy", bus.busy, 0);
    chk("w1_not_loaded", asm_q, 24'h332211);
    // en drop after two bytes; done in LOAD and START is ignored
    bus.in_valid = 1'b1; din = 8'hA1;
    nxt(); din = 8'hA2;
    nxt(); bus.en = 1'b0; din = 8'h44; bus.done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("w2_en_low_ready", bus.in_ready, 0);
      chk("w2_en_low_ld", bus.ld_reg, 0);
      chk("w2_en_low_cnt", bus.byte_cnt, 2);
      chk("w2_en_low_busy", bus.busy, 0);
      nxt();
    end
    bus.en = 1'b1; bus.done = 1'b0; #1;
    chk("w2_resume_ld", {bus.ld_reg, bus.icc}, 2'b11);
    nxt(); bus.in_valid = 1'b0; bus.done = 1'b1; #1;
    chk("w2_start", bus.start, 1);
    chk("w2_x", asm_q[15:0], 16'hA2A1);
    chk("w2_y", asm_q[23:16], 8'h44);
    nxt(); bus.done = 1'b0; #1;
    chk("w2_start_done_ignored", {bus.busy, bus.in_ready, bus.start}, 3'b100);
    nxt(); #1;
    chk("w2_still_wait", {bus.busy, bus.in_ready}, 2'b10);
    for (int i = 0; i < 20; i++) nxt();
    #1;
    chk("w2_long_wait_busy", bus.busy, 1);
    chk("w2_long_wait_err", bus.err, 0);
    bus.done = 1'b1;
    nxt(); bus.done = 1'b0; #1;
    chk("w2_back_ready", bus.in_ready, 1);
    // reset after one byte abandons the partial word
    bus.in_valid = 1'b1; din = 8'h01;
    nxt(); bus.in_valid = 1'b0; rst = 1'b1; #1;
    chk("rst_mid_cnt", bus.byte_cnt, 0);
    chk("rst_mid_ready", bus.in_ready, 0);
    nxt(); rst = 1'b0; #1;
    chk("rst_mid_nostart", bus.start, 0);
    chk("rst_mid_cnt_after", bus.byte_cnt, 0);
    bus.in_valid = 1'b1; din = 8'h0A;
    nxt(); din = 8'h0B; #1;
    chk("w3_cnt1", bus.byte_cnt, 1);
    nxt(); din = 8'h0C;
    nxt(); bus.in_valid = 1'b0; #1;
    chk("w3_start", bus.start, 1);
    chk("w3_word", asm_q, 24'h0C0B0A);
`ifdef INPUT_LOADER_TIMEOUT_EN
    // timeout: err 8 cycles after WAIT entry, in_ready returns
    for (int i = 0; i < 8; i++) begin
      nxt(); #1;
      chk("to_wait_err", bus.err, 0);
      chk("to_wait_ready", bus.in_ready, 0);
    end
    nxt(); #1;
    chk("to_err", bus.err, 1);
    chk("to_ready", bus.in_ready, 1);
    nxt(); #1;
    chk("to_err_pulse", bus.err, 0);
    bus.in_valid = 1'b1;
    nxt(); nxt(); nxt(); bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) nxt();
    bus.done = 1'b1;
    nxt(); bus.done = 1'b0; #1;
    chk("to_done_prio_err", bus.err, 0);
    chk("to_done_prio_ready", bus.in_ready, 1);
`else
    nxt(); bus.done = 1'b1;
    nxt(); bus.done = 1'b0; #1;
    chk("w3_back_ready", bus.in_ready, 1);
    chk("w3_err", bus.err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
